// File: rtl/adc_lvds_serializer.sv
// adc_lvds_serializer: ADC emulator that streams WIDTH-bit samples as rise/fall bit pairs with an FCO-style FRAME marker.
module adc_lvds_serializer #(
    parameter int               WIDTH         = 12,
    parameter bit               LSB_FIRST     = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_PATTERN  = 12'h800,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 12'hAC3,
    parameter int               UCNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic              TRAIN,
    output logic              D_RISE,
    output logic              D_FALL,
    output logic              FRAME,
    output logic [UCNT_W-1:0] UNDERFLOW_CNT
);
    localparam int NPAIR = WIDTH / 2;
    localparam int CW = $clog2(NPAIR);
    localparam logic [CW-1:0] LAST = CW'(NPAIR - 1);
    localparam logic [CW-1:0] HALF = CW'((NPAIR + 1) / 2);

    logic [CW-1:0]    pair_cnt, cnt_nxt;
    logic [WIDTH-1:0] sh, sh_nxt, hold, src;
    logic             hold_v, armed, load, accept;

    assign load    = pair_cnt == LAST;
    assign S_READY = RST_N & (!hold_v | load);
    assign accept  = S_VALID & S_READY;

    always_comb begin
        src     = TRAIN ? TRAIN_PATTERN : hold_v ? hold : IDLE_PATTERN;
        sh_nxt  = load ? src : LSB_FIRST ? sh >> 2 : sh << 2;
        cnt_nxt = load ? '0 : pair_cnt + 1'b1;
    end

    // Outputs are taken from the next-state values so they line up with pair_cnt.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pair_cnt      <= LAST;
            sh            <= '0;
            hold_v        <= 1'b0;
            armed         <= 1'b0;
            UNDERFLOW_CNT <= '0;
            D_RISE        <= 1'b0;
            D_FALL        <= 1'b0;
            FRAME         <= 1'b0;
        end else begin
            pair_cnt <= cnt_nxt;
            sh       <= sh_nxt;
            D_RISE   <= LSB_FIRST ? sh_nxt[0] : sh_nxt[WIDTH-1];
            D_FALL   <= LSB_FIRST ? sh_nxt[1] : sh_nxt[WIDTH-2];
            FRAME    <= cnt_nxt < HALF;
            hold_v   <= accept | (hold_v & !(load & !TRAIN));
            if (accept) begin
                hold  <= S_DATA;
                armed <= 1'b1;
            end
            if (load && !TRAIN && !hold_v && armed && !(&UNDERFLOW_CNT))
                UNDERFLOW_CNT <= UNDERFLOW_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_lvds_serializer.sv
// tb_adc_lvds_serializer: directed frame-by-frame checks of pairs, FRAME, S_READY and the underflow counter.
module tb_adc_lvds_serializer;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [11:0] S_DATA = '0;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic        TRAIN = 1'b0;
    logic        D_RISE, D_FALL, FRAME;
    logic [15:0] UNDERFLOW_CNT;
    int          checks = 0;
    int          failures = 0;

    adc_lvds_serializer dut (
        .CLK(CLK), .RST_N(RST_N), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .TRAIN(TRAIN), .D_RISE(D_RISE), .D_FALL(D_FALL), .FRAME(FRAME), .UNDERFLOW_CNT(UNDERFLOW_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0; S_VALID = 1'b0; TRAIN = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_out", {D_RISE, D_FALL, FRAME}, 3'b000);
        check("rst_rdy", S_READY, 1'b0);
        check("rst_ucnt", UNDERFLOW_CNT, 0);
        RST_N = 1'b1;
    endtask

    // Checks n pairs of word w (MSB first). rdy: 0 none, 1 high only on pair 5, 2 always high.
    // After pair 0, S_VALID/S_DATA take v0/d0; after pair 1, S_VALID drops if drop is set.
    task automatic frame(input string tag, input logic [11:0] w, input int n, input int rdy,
                         input logic v0, input logic [11:0] d0, input logic drop);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check({tag, "_pair"}, {D_RISE, D_FALL}, {w[11-2*k], w[10-2*k]});
            check({tag, "_frame"}, FRAME, k < 3);
            if (rdy == 1) check({tag, "_rdy"}, S_READY, k == 5);
            if (rdy == 2) check({tag, "_rdy"}, S_READY, 1'b1);
            if (k == 0) begin
                S_VALID = v0;
                S_DATA  = d0;
            end
            if (k == 1 && drop) S_VALID = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 6; i++) frame("t1", 12'h800, 6, 2, 1'b0, 12'h0, 1'b0);
        check("t1_ucnt", UNDERFLOW_CNT, 0);

        do_reset();
        frame("t2_idle", 12'h800, 6, 0, 1'b1, 12'hABC, 1'b1);
        frame("t2", 12'hABC, 6, 2, 1'b0, 12'h0, 1'b0);

        do_reset();
        S_VALID = 1'b1;
        S_DATA  = 12'd1;
        for (int f = 0; f <= 8; f++)
            frame("t3", f == 0 ? 12'h800 : 12'(f), 6, f < 8 ? 1 : 2, f < 7, 12'(f + 2), 1'b0);
        check("t3_ucnt", UNDERFLOW_CNT, 0);

        do_reset();
        frame("t4_idle", 12'h800, 6, 0, 1'b1, 12'h123, 1'b1);
        frame("t4", 12'h123, 6, 2, 1'b0, 12'h0, 1'b0);
        check("t4_ucnt0", UNDERFLOW_CNT, 0);
        frame("t4_under", 12'h800, 6, 2, 1'b0, 12'h0, 1'b0);
        check("t4_ucnt1", UNDERFLOW_CNT, 1);

        do_reset();
        frame("t5_idle", 12'h800, 6, 0, 1'b1, 12'h456, 1'b1);
        TRAIN = 1'b1;
        frame("t5_train", 12'hAC3, 6, 1, 1'b0, 12'h0, 1'b0);
        TRAIN = 1'b0;
        frame("t5", 12'h456, 6, 2, 1'b0, 12'h0, 1'b0);
        check("t5_ucnt", UNDERFLOW_CNT, 0);

        do_reset();
        frame("t6_idle", 12'h800, 6, 0, 1'b1, 12'hABC, 1'b1);
        frame("t6_abc", 12'hABC, 4, 0, 1'b1, 12'h555, 1'b1);
        check("t6_hold_rdy", S_READY, 1'b0);
        RST_N = 1'b0;
        @(negedge CLK);
        check("t6_out", {D_RISE, D_FALL, FRAME}, 3'b000);
        check("t6_rdy", S_READY, 1'b0);
        check("t6_ucnt", UNDERFLOW_CNT, 0);
        RST_N = 1'b1;
        frame("t6_after", 12'h800, 6, 2, 1'b0, 12'h0, 1'b0);
        check("t6_ucnt_end", UNDERFLOW_CNT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
